nes_joypad: RTL and testbench
=============================

// Module: nes_joypad
// PURPOSE
//  Emulates standard NES controller 1 at CPU registers $4016/$4017 and sits downstream of the Nios soft system.
//  Inputs are the two USB-keyboard keycode exports (keycode, keycode2); keys map to the 8 NES buttons.
//  It implements the $4016 strobe latch and the serial read-shift behaviour that games poll.
//  It runs in the NES clock domain; CPU accesses are qualified by a one-cycle cpu_ce enable.
// PARAMETERS
//  SOCD_CLEAN   1     1: Up+Down both pressed -> both cleared; Left+Right both pressed -> both cleared. 0: pass both.
//  OPEN_BUS_HI  3'b010  Value driven on rdata[7:5] (open-bus emulation); rdata[4:1] are always 0.
// PORTS
//  Clk          in   1   system clock (single domain)
//  Reset        in   1   synchronous, active-high
//  keycode0     in   8   USB HID keycode, first held key (0x00 = none)
//  keycode1     in   8   USB HID keycode, second held key (0x00 = none)
//  cpu_ce       in   1   one-Clk pulse per CPU cycle; all CPU-side effects require cpu_ce=1
//  cpu_addr     in   16  CPU address bus
//  cpu_we       in   1   CPU write request
//  cpu_re       in   1   CPU read request
//  cpu_wdata    in   8   CPU write data
//  rdata        out  8   read data for $4016/$4017
//  rdata_valid  out  1   one-Clk pulse: rdata holds the result of the accepted read
//  buttons      out  8   registered live button mask (debug/LEDs); bit order A,B,Sel,Start,Up,Down,Left,Right = [0..7]
// BEHAVIOUR
//  Reset: buttons=0, strobe=0, shreg=8'h00, rdata=8'h00, rdata_valid=0.
//  Decode each keycode separately; OR the two masks; apply SOCD_CLEAN; register into buttons (1 Clk latency).
//   Key map: A=0x1B(X), B=0x1D(Z), Select=0x2B(Tab), Start=0x28(Enter), Up=0x52, Down=0x51, Left=0x50, Right=0x4F.
//   Any other code, including 0x00, contributes nothing. Equal keycodes are harmless because the masks are ORed.
//  Write accept: cpu_ce & cpu_we & cpu_addr==16'h4016 -> strobe <= cpu_wdata[0].
//   Writes to $4017 are ignored here; that address belongs to the APU.
//  Shift register (each Clk):
//   strobe=1 -> shreg <= buttons (continuous reload; a press during strobe is reflected the next cycle).
//   strobe=0 and $4016 read accepted -> shreg <= {1'b1, shreg[7:1]}.
//    After 8 reads, bit0 is 1 for every further read, matching an official pad.
//   Any other case -> hold.
//  Read accept: cpu_ce & cpu_re & (addr==$4016 | addr==$4017). Next Clk: rdata_valid=1 and rdata is set as follows.
//   $4016: rdata = {OPEN_BUS_HI, 4'b0, b}. b = buttons[0] when strobe=1; otherwise shreg[0] from before the shift.
//   $4017: rdata = {OPEN_BUS_HI, 5'b0} (pad 2 absent); no state change.
//  Read with strobe=1: returns current A, no shift, no state change.
//  Simultaneous we and re in one accepted cycle: the write is applied; the read returns the pre-write value and does not shift.
//  cpu_re/cpu_we held for several Clk with a single cpu_ce: exactly one action.
//  cpu_ce=0: no CPU-side state change; rdata holds its last value; rdata_valid=0.
//  Reset mid-sequence: everything returns to reset values in the same Clk. The first read after reset (strobe=0) returns b=0.
// STRUCTURE
//  Shared package nes_pkg:
//   keycode constants KC_A..KC_RIGHT;
//   button index constants BTN_A=0..BTN_RIGHT=7;
//   address constants JOY1_ADDR=16'h4016, JOY2_ADDR=16'h4017.
//  Sub-module nes_key_decode (combinational, keycode[7:0] -> mask[7:0]), instantiated twice.
//  Top holds: SOCD logic, buttons register, strobe FF, shreg, read/write decode, rdata pipeline register.
// TESTING
//  1. Reset, then read $4016 once with no keys -> rdata=8'h40, rdata_valid pulses once.
//  2. keycode0=0x1B, keycode1=0x28; write $4016=1 then 0; 10 reads -> b sequence 1,0,0,1,0,0,0,0,1,1.
//  3. Strobe held at 1: set keycode0=0x1B, then 0x00; read after each -> b=1, then b=0. shreg never shifts.
//  4. SOCD_CLEAN=1, keycode0=0x52, keycode1=0x51 -> buttons=8'h00. With SOCD_CLEAN=0 -> buttons=8'h30.
//  5. cpu_re held 4 Clk with one cpu_ce pulse -> one rdata_valid and one shift. Reads of $4017 -> 8'h40, shreg unchanged.
//  6. Reset asserted after 3 of 8 reads -> next Clk all outputs 0. A read with strobe=0 then returns b=0, and 8 reads later b=1.

Source files
------------

// File: rtl/nes_joypad_pkg.sv
// ============================================================================
// Module : nes_pkg
// Brief  : Shared keycode, button-index and address constants for the joypad.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nes_pkg;

  // USB HID keycodes that map onto NES buttons
  localparam logic [7:0] KC_A      = 8'h1B;
  localparam logic [7:0] KC_B      = 8'h1D;
  localparam logic [7:0] KC_SELECT = 8'h2B;
  localparam logic [7:0] KC_START  = 8'h28;
  localparam logic [7:0] KC_UP     = 8'h52;
  localparam logic [7:0] KC_DOWN   = 8'h51;
  localparam logic [7:0] KC_LEFT   = 8'h50;
  localparam logic [7:0] KC_RIGHT  = 8'h4F;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  typedef logic [7:0] btn_mask_t;

endpackage

`default_nettype wire

// File: rtl/nes_joypad_if.sv
// ============================================================================
// Module : nes_joypad_if
// Brief  : CPU-side register access bus for the joypad ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nes_joypad_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_wdata;
  logic [7:0]  rdata;
  logic        rdata_valid;

  modport master (
    output cpu_ce, cpu_addr, cpu_we, cpu_re, cpu_wdata,
    input  rdata, rdata_valid
  );

  modport slave (
    input  cpu_ce, cpu_addr, cpu_we, cpu_re, cpu_wdata,
    output rdata, rdata_valid
  );
endinterface

`default_nettype wire

// File: rtl/nes_joypad_key_decode.sv
// ============================================================================
// Module : nes_key_decode
// Brief  : Maps one USB HID keycode onto a one-hot NES button mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nes_key_decode
  import nes_pkg::*;
(
  input  logic [7:0] keycode,
  output btn_mask_t  mask
);

  always_comb begin
    mask = '0;
    case (keycode)
      KC_A:      mask[BTN_A]      = 1'b1;
      KC_B:      mask[BTN_B]      = 1'b1;
      KC_SELECT: mask[BTN_SELECT] = 1'b1;
      KC_START:  mask[BTN_START]  = 1'b1;
      KC_UP:     mask[BTN_UP]     = 1'b1;
      KC_DOWN:   mask[BTN_DOWN]   = 1'b1;
      KC_LEFT:   mask[BTN_LEFT]   = 1'b1;
      KC_RIGHT:  mask[BTN_RIGHT]  = 1'b1;
      default:   mask = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nes_joypad.sv
// ============================================================================
// Module : nes_joypad
// Brief  : NES controller-1 emulation at $4016/$4017 driven by USB keycodes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nes_joypad
  import nes_pkg::*;
#(
  parameter bit         SOCD_CLEAN  = 1'b1,
  parameter logic [2:0] OPEN_BUS_HI = 3'b010
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       keycode0,
  input  logic [7:0]       keycode1,
  nes_joypad_if.slave      bus,
  output btn_mask_t        buttons
);

  btn_mask_t mask0;
  btn_mask_t mask1;
  btn_mask_t raw_btn;
  btn_mask_t next_btn;

  logic       strobe;
  logic [7:0] shreg;
  logic [7:0] rdata_q;
  logic       rdata_valid_q;

  logic wr_acc;
  logic rd1_acc;
  logic rd2_acc;
  logic shift_en;
  logic read_bit;
  logic unused_wdata;

  nes_key_decode u_dec0 (.keycode(keycode0), .mask(mask0));
  nes_key_decode u_dec1 (.keycode(keycode1), .mask(mask1));

  assign raw_btn = mask0 | mask1;

  // Opposing directions cancel so a game never sees an impossible d-pad state
  always_comb begin
    next_btn = raw_btn;
    if (SOCD_CLEAN) begin
      if (raw_btn[BTN_UP] && raw_btn[BTN_DOWN]) begin
        next_btn[BTN_UP]   = 1'b0;
        next_btn[BTN_DOWN] = 1'b0;
      end
      if (raw_btn[BTN_LEFT] && raw_btn[BTN_RIGHT]) begin
        next_btn[BTN_LEFT]  = 1'b0;
        next_btn[BTN_RIGHT] = 1'b0;
      end
    end
  end

  assign wr_acc  = bus.cpu_ce && bus.cpu_we && (bus.cpu_addr == JOY1_ADDR);
  assign rd1_acc = bus.cpu_ce && bus.cpu_re && (bus.cpu_addr == JOY1_ADDR);
  assign rd2_acc = bus.cpu_ce && bus.cpu_re && (bus.cpu_addr == JOY2_ADDR);

  // A read sharing its cycle with a write sees the old state and does not shift
  assign shift_en = rd1_acc && !strobe && !wr_acc;
  assign read_bit = strobe ? buttons[BTN_A] : shreg[0];

  assign unused_wdata = ^bus.cpu_wdata[7:1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      buttons       <= '0;
      strobe        <= 1'b0;
      shreg         <= 8'h00;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      buttons       <= next_btn;
      rdata_valid_q <= rd1_acc || rd2_acc;

      if (wr_acc) begin
        strobe <= bus.cpu_wdata[0];
      end

      // Shifting in ones makes reads past the eighth return 1, as on a real pad
      if (strobe) begin
        shreg <= buttons;
      end else if (shift_en) begin
        shreg <= {1'b1, shreg[7:1]};
      end

      if (rd1_acc) begin
        rdata_q <= {OPEN_BUS_HI, 4'b0000, read_bit};
      end else if (rd2_acc) begin
        rdata_q <= {OPEN_BUS_HI, 5'b00000};
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_joypad.sv
// ============================================================================
// Module : tb_nes_joypad
// Brief  : Directed plus randomized check of nes_joypad against a latch/count model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nes_joypad;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] k0;
  logic [7:0] k1;
  logic [7:0] btn1;
  logic [7:0] btn2;

  always #5 clk = ~clk;

  nes_joypad_if bus ();
  nes_joypad_if bus2 ();

  nes_joypad #(.SOCD_CLEAN(1'b1), .OPEN_BUS_HI(3'b010)) dut (
    .Clk(clk), .Reset(rst), .keycode0(k0), .keycode1(k1), .bus(bus), .buttons(btn1)
  );

  nes_joypad #(.SOCD_CLEAN(1'b0), .OPEN_BUS_HI(3'b010)) dut2 (
    .Clk(clk), .Reset(rst), .keycode0(k0), .keycode1(k1), .bus(bus2), .buttons(btn2)
  );

  int total = 0;
  int bad   = 0;

  // Model: the pad latches a snapshot when strobe is high; reads walk through it
  logic       m_strobe;
  logic [7:0] m_latch;
  int         m_n;
  logic [7:0] m_rdata;
  logic [7:0] m_btn;

  logic [7:0] kc_tab [8] = '{8'h1B, 8'h1D, 8'h2B, 8'h28, 8'h52, 8'h51, 8'h50, 8'h4F};
  logic [9:0] t2_seq = 10'b11_0000_1001;

  function automatic logic [7:0] press_mask(input logic [7:0] kc);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) if (kc == kc_tab[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] model_buttons(input logic [7:0] a, input logic [7:0] b, input bit socd);
    logic [7:0] m = press_mask(a) | press_mask(b);
    if (socd && m[4] && m[5]) m[5:4] = 2'b00;
    if (socd && m[6] && m[7]) m[7:6] = 2'b00;
    return m;
  endfunction

  function automatic logic [7:0] rand_key();
    int idx = $urandom_range(0, 9);
    if (idx < 8) return kc_tab[idx];
    if (idx == 8) return 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    k0 = a;
    k1 = b;
    repeat (2) @(negedge clk);
    m_btn = model_buttons(a, b, 1'b1);
    check8("buttons", btn1, m_btn);
    check8("buttons_nosocd", btn2, model_buttons(a, b, 1'b0));
    if (m_strobe) begin
      m_latch = m_btn;
      m_n     = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("rst_buttons", btn1, 8'h00);
    check8("rst_rdata", bus.rdata, 8'h00);
    check8("rst_valid", {7'b0, bus.rdata_valid}, 8'h00);
    rst = 1'b0;
    m_strobe = 1'b0;
    m_latch  = 8'h00;
    m_n      = 0;
    m_rdata  = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  // One CPU access; request lines may stay up for `hold` extra cycles without ce
  task automatic cpu(input logic ce, input logic we, input logic re,
                     input logic [15:0] addr, input logic [7:0] wd, input int hold);
    logic acc_rd;
    logic wr;
    logic exp_b;
    @(negedge clk);
    bus.cpu_ce    = ce;
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
    bus.cpu_ce = 1'b0;
    acc_rd = ce && re && (addr == 16'h4016 || addr == 16'h4017);
    wr     = ce && we && (addr == 16'h4016);
    if (acc_rd) begin
      if (addr == 16'h4016) begin
        exp_b   = m_strobe ? m_btn[0] : ((m_n < 8) ? m_latch[m_n] : 1'b1);
        m_rdata = {3'b010, 4'b0000, exp_b};
      end else begin
        m_rdata = 8'h40;
      end
    end
    check8("rdata_valid", {7'b0, bus.rdata_valid}, {7'b0, acc_rd});
    check8("rdata", bus.rdata, m_rdata);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check8("hold_valid", {7'b0, bus.rdata_valid}, 8'h00);
      check8("hold_rdata", bus.rdata, m_rdata);
    end
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    if (acc_rd && addr == 16'h4016 && !m_strobe && !wr) m_n++;
    if (wr) begin
      if (m_strobe || wd[0]) begin
        m_latch = m_btn;
        m_n     = 0;
      end
      m_strobe = wd[0];
    end
  endtask

  initial begin
    rst = 1'b0;
    k0  = 8'h00;
    k1  = 8'h00;
    bus.cpu_ce = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_re = 1'b0;
    bus.cpu_addr = 16'h0000;  bus.cpu_wdata = 8'h00;
    bus2.cpu_ce = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_re = 1'b0;
    bus2.cpu_addr = 16'h0000; bus2.cpu_wdata = 8'h00;
    m_strobe = 1'b0; m_latch = 8'h00; m_n = 0; m_rdata = 8'h00; m_btn = 8'h00;

    // Reset and an idle-pad read
    do_reset();
    set_keys(8'h00, 8'h00);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t1_rdata", bus.rdata, 8'h40);

    // A + Start latched and shifted out, then trailing ones
    set_keys(8'h1B, 8'h28);
    cpu(1, 1, 0, 16'h4016, 8'h01, 0);
    cpu(1, 1, 0, 16'h4016, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      logic [9:0] seq = t2_seq;
      cpu(1, 0, 1, 16'h4016, 8'h00, 0);
      check8("t2_seq", {7'b0, bus.rdata[0]}, {7'b0, seq[i]});
    end

    // Strobe held high tracks A live
    set_keys(8'h00, 8'h00);
    cpu(1, 1, 0, 16'h4016, 8'h01, 0);
    set_keys(8'h1B, 8'h00);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t3_live_a", {7'b0, bus.rdata[0]}, 8'h01);
    set_keys(8'h00, 8'h00);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t3_live_clr", {7'b0, bus.rdata[0]}, 8'h00);
    cpu(1, 1, 0, 16'h4016, 8'h00, 0);
    for (int i = 0; i < 9; i++) cpu(1, 0, 1, 16'h4016, 8'h00, 0);

    // Opposing directions
    set_keys(8'h52, 8'h51);
    check8("t4_socd_on", btn1, 8'h00);
    check8("t4_socd_off", btn2, 8'h30);
    set_keys(8'h50, 8'h4F);
    set_keys(8'h1B, 8'h1B);

    // Long request with a single enable, $4017, ce=0 and simultaneous we/re
    set_keys(8'h1D, 8'h00);
    cpu(1, 1, 0, 16'h4016, 8'h01, 0);
    cpu(1, 1, 0, 16'h4016, 8'h00, 0);
    cpu(1, 0, 1, 16'h4016, 8'h00, 3);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t5_one_shift", {7'b0, bus.rdata[0]}, 8'h01);
    cpu(1, 0, 1, 16'h4017, 8'h00, 0);
    check8("t5_joy2", bus.rdata, 8'h40);
    cpu(1, 1, 0, 16'h4017, 8'h01, 0);
    cpu(0, 1, 1, 16'h4016, 8'h01, 0);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    cpu(1, 1, 1, 16'h4016, 8'h01, 0);
    cpu(1, 1, 1, 16'h4016, 8'h00, 0);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);

    // Reset partway through a read sequence
    set_keys(8'h1B, 8'h28);
    cpu(1, 1, 0, 16'h4016, 8'h01, 0);
    cpu(1, 1, 0, 16'h4016, 8'h00, 0);
    for (int i = 0; i < 3; i++) cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    do_reset();
    m_btn = model_buttons(k0, k1, 1'b1);
    cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t6_first", {7'b0, bus.rdata[0]}, 8'h00);
    for (int i = 0; i < 8; i++) cpu(1, 0, 1, 16'h4016, 8'h00, 0);
    check8("t6_ninth", {7'b0, bus.rdata[0]}, 8'h01);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int op = $urandom_range(0, 11);
      logic [7:0] wd = 8'($urandom_range(0, 255));
      logic ce = ($urandom_range(0, 7) != 0);
      case (op)
        0:       set_keys(rand_key(), rand_key());
        1, 2:    cpu(ce, 1, 0, 16'h4016, wd, 0);
        3, 4, 5, 6: cpu(ce, 0, 1, 16'h4016, wd, $urandom_range(0, 1));
        7:       cpu(ce, 0, 1, 16'h4017, wd, 0);
        8:       cpu(ce, 1, 0, 16'h4017, wd, 0);
        9:       cpu(ce, 1, 1, 16'h4016, wd, 0);
        10:      cpu(ce, 0, 1, 16'h4015, wd, 0);
        default: if ($urandom_range(0, 15) == 0) do_reset(); else cpu(0, 0, 0, 16'h0000, wd, 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
